pr_busy_table: RTL

//  Physical-register ready (busy) scoreboard, directly downstream of the wakeup-tag source stage.

---
 rtl/pr_busy_table_pkg.sv | 23 ++
 rtl/pr_busy_table_if.sv | 41 ++++
 rtl/pr_busy_table_tag_match.sv | 21 ++
 rtl/pr_busy_table.sv | 85 ++++++++
 4 files changed

// File: rtl/pr_busy_table_pkg.sv
// Shared widths, tag type and helpers for the physical-register busy table.
package pr_busy_table_pkg;

    localparam int PR_W         = 6;
    localparam int NUM_PR       = 1 << PR_W;
    localparam int NUM_WB_PORTS = 4;
    localparam int CNT_W        = PR_W + 1;

    typedef logic [PR_W-1:0]  pr_tag_t;
    typedef logic [CNT_W-1:0] pr_cnt_t;

    localparam pr_tag_t NULL_PR = '0;

    function automatic pr_cnt_t popcount(input logic [NUM_PR-1:0] bits);
        pr_cnt_t cnt;
        cnt = '0;
        for (int i = 0; i < NUM_PR; i++) begin
            cnt = cnt + pr_cnt_t'(bits[i]);
        end
        return cnt;
    endfunction

endpackage

// File: rtl/pr_busy_table_if.sv
// Rename/wakeup-side bundle of the busy table: allocations, wakeup tags, source reads.
interface pr_busy_table_if;
    import pr_busy_table_pkg::*;

    logic    flush;
    logic    alloc0_vld;
    pr_tag_t alloc0_PR;
    logic    alloc1_vld;
    pr_tag_t alloc1_PR;
    pr_tag_t ALU0_dest;
    pr_tag_t ALU1_dest;
    pr_tag_t AGU_dest;
    pr_tag_t BRU_dest;
    pr_tag_t inst0_src1_PR;
    pr_tag_t inst0_src2_PR;
    pr_tag_t inst1_src1_PR;
    pr_tag_t inst1_src2_PR;
    logic    inst0_src1_rdy;
    logic    inst0_src2_rdy;
    logic    inst1_src1_rdy;
    logic    inst1_src2_rdy;
    pr_cnt_t busy_cnt;

    // No handshake: every field is sampled every cycle; *_vld qualifies only the alloc tags.
    modport master (
        output flush, alloc0_vld, alloc0_PR, alloc1_vld, alloc1_PR,
        output ALU0_dest, ALU1_dest, AGU_dest, BRU_dest,
        output inst0_src1_PR, inst0_src2_PR, inst1_src1_PR, inst1_src2_PR,
        input  inst0_src1_rdy, inst0_src2_rdy, inst1_src1_rdy, inst1_src2_rdy,
        input  busy_cnt
    );

    modport slave (
        input  flush, alloc0_vld, alloc0_PR, alloc1_vld, alloc1_PR,
        input  ALU0_dest, ALU1_dest, AGU_dest, BRU_dest,
        input  inst0_src1_PR, inst0_src2_PR, inst1_src1_PR, inst1_src2_PR,
        output inst0_src1_rdy, inst0_src2_rdy, inst1_src1_rdy, inst1_src2_rdy,
        output busy_cnt
    );

endinterface

// File: rtl/pr_busy_table_tag_match.sv
// One tag against all wakeup tags; the null tag never hits.
module pr_tag_match
    import pr_busy_table_pkg::*;
(
    input  pr_tag_t                    tag_i,
    input  pr_tag_t [NUM_WB_PORTS-1:0] wb_tags_i,
    output logic                       hit_o
);

    logic [NUM_WB_PORTS-1:0] eq;

    always_comb begin
        eq = '0;
        for (int i = 0; i < NUM_WB_PORTS; i++) begin
            eq[i] = (wb_tags_i[i] == tag_i);
        end
    end

    assign hit_o = (tag_i != NULL_PR) && (|eq);

endmodule

// File: rtl/pr_busy_table.sv
// Physical-register busy scoreboard: set on rename allocation, cleared by wakeup tags,
// read combinationally with same-cycle wakeup bypass.
module pr_busy_table
    import pr_busy_table_pkg::*;
(
    input logic                clk,
    input logic                rst,
    pr_busy_table_if.slave     bt_if
);

    logic [NUM_PR-1:0]         busy_q;
    logic [NUM_PR-1:0]         busy_d;
    pr_cnt_t                   busy_cnt_q;
    logic [NUM_PR-1:0]         wake_hit;
    pr_tag_t [NUM_WB_PORTS-1:0] wb_tags;

    assign wb_tags = {bt_if.BRU_dest, bt_if.AGU_dest, bt_if.ALU1_dest, bt_if.ALU0_dest};

    assign wake_hit[0] = 1'b0;
    for (genvar p = 1; p < NUM_PR; p++) begin : g_pr_match
        pr_tag_match u_match (
            .tag_i     (pr_tag_t'(p)),
            .wb_tags_i (wb_tags),
            .hit_o     (wake_hit[p])
        );
    end

    // Priority per PR: flush, then allocation, then wakeup.
    always_comb begin
        busy_d = busy_q;
        for (int p = 1; p < NUM_PR; p++) begin
            if (bt_if.flush) begin
                busy_d[p] = 1'b0;
            end else if ((bt_if.alloc0_vld && bt_if.alloc0_PR == pr_tag_t'(p)) ||
                         (bt_if.alloc1_vld && bt_if.alloc1_PR == pr_tag_t'(p))) begin
                busy_d[p] = 1'b1;
            end else if (wake_hit[p]) begin
                busy_d[p] = 1'b0;
            end
        end
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_q     <= '0;
            busy_cnt_q <= '0;
        end else begin
            busy_q     <= busy_d;
            busy_cnt_q <= popcount(busy_d);
        end
    end

    pr_tag_t [3:0] src_tag;
    logic    [3:0] src_hit;
    logic    [3:0] src_rdy;

    assign src_tag = {bt_if.inst1_src2_PR, bt_if.inst1_src1_PR,
                      bt_if.inst0_src2_PR, bt_if.inst0_src1_PR};

    for (genvar s = 0; s < 4; s++) begin : g_src
        logic dep;
        pr_tag_match u_match (
            .tag_i     (src_tag[s]),
            .wb_tags_i (wb_tags),
            .hit_o     (src_hit[s])
        );
        // Slot 1 sources depend on slot 0's same-cycle destination; slot 0 never does.
        if (s >= 2) begin : g_dep
            assign dep = bt_if.alloc0_vld && (bt_if.alloc0_PR != NULL_PR) &&
                         (src_tag[s] == bt_if.alloc0_PR);
        end else begin : g_nodep
            assign dep = 1'b0;
        end
        assign src_rdy[s] = rst ||
                            (!dep && ((src_tag[s] == NULL_PR) || !busy_q[src_tag[s]] || src_hit[s]));
    end

    assign bt_if.inst0_src1_rdy = src_rdy[0];
    assign bt_if.inst0_src2_rdy = src_rdy[1];
    assign bt_if.inst1_src1_rdy = src_rdy[2];
    assign bt_if.inst1_src2_rdy = src_rdy[3];
    assign bt_if.busy_cnt       = busy_cnt_q;

endmodule
